// File: rtl/bslu_pkg.sv
// Shared definitions for the BSLU sequencer: opcodes, op bit positions,
// register indices, instruction field positions and the micro-op decoder.
package bslu_pkg;

  typedef enum logic [2:0] {
    OPC_NOP = 3'd0,
    OPC_MOV = 3'd1,
    OPC_SET = 3'd2,
    OPC_NOT = 3'd3,
    OPC_AND = 3'd4,
    OPC_OR  = 3'd5,
    OPC_XOR = 3'd6,
    OPC_SEL = 3'd7
  } opcode_e;

  localparam int OP_MOV_B  = 0;
  localparam int OP_SET_B  = 1;
  localparam int OP_SETV_B = 2;
  localparam int OP_NOT_B  = 3;
  localparam int OP_AND_B  = 4;
  localparam int OP_OR_B   = 5;
  localparam int OP_XOR_B  = 6;
  localparam int OP_SEL_B  = 7;

  localparam int REG_SA = 0;
  localparam int REG_CR = 1;
  localparam int REG_PR = 2;
  localparam int REG_T1 = 3;

  localparam int INSTR_W  = 16;
  localparam int F_OPC_LO = 13;
  localparam int F_IMM    = 12;
  localparam int F_RD_LO  = 10;
  localparam int F_RS1_LO = 8;
  localparam int F_RS2_LO = 6;
  localparam int F_RPT_LO = 0;
  localparam int RPT_W    = 6;

  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} seq_state_e;

  typedef struct packed {
    logic [7:0] op;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
  } uop_t;

  function automatic uop_t decode_uop(input logic [INSTR_W-1:0] instr);
    uop_t       u;
    opcode_e    opc;
    logic [3:0] rd_oh, rs1_oh, rs2_oh;
    u      = '0;
    opc    = opcode_e'(instr[F_OPC_LO +: 3]);
    rd_oh  = 4'(1 << instr[F_RD_LO  +: 2]);
    rs1_oh = 4'(1 << instr[F_RS1_LO +: 2]);
    rs2_oh = 4'(1 << instr[F_RS2_LO +: 2]);
    case (opc)
      OPC_MOV: u.op[OP_MOV_B] = 1'b1;
      OPC_SET: begin
        u.op[OP_SET_B]  = 1'b1;
        u.op[OP_SETV_B] = instr[F_IMM];
      end
      OPC_NOT: u.op[OP_NOT_B] = 1'b1;
      OPC_AND: u.op[OP_AND_B] = 1'b1;
      OPC_OR:  u.op[OP_OR_B]  = 1'b1;
      OPC_XOR: u.op[OP_XOR_B] = 1'b1;
      OPC_SEL: u.op[OP_SEL_B] = 1'b1;
      default: ;
    endcase
    // nop keeps every select at zero; set has no sources; unary ops have no rs2
    if (opc != OPC_NOP) u.rd = rd_oh;
    if (opc != OPC_NOP && opc != OPC_SET) u.rs1 = rs1_oh;
    if (opc inside {OPC_AND, OPC_OR, OPC_XOR, OPC_SEL}) u.rs2 = rs2_oh;
    return u;
  endfunction

endpackage

// File: rtl/bslu_seq_fifo.sv
// Instruction FIFO for the BSLU sequencer. DEPTH must be a power of two so
// the pointers wrap naturally; count carries one extra bit to tell full.
module bslu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_ok ? AW'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? AW'(rd_ptr_q + 1'b1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop_ok)      cnt_d = (AW+1)'(cnt_q + 1'b1);
    else if (pop_ok && !push_ok) cnt_d = (AW+1)'(cnt_q - 1'b1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // storage needs no reset: empty pointers make stale entries unreachable
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bslu_bs3r_seq.sv
// BSLU repeat sequencer: queues packed instructions and issues each one as
// rpt+1 one-hot micro-ops. Define BSLU_SEQ_PERF_CNT_EN to add perf_cnt.
module bslu_bs3r_seq
  import bslu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  input  logic        stall,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic [7:0]  op,
  output logic        busy
`ifdef BSLU_SEQ_PERF_CNT_EN
  ,
  output logic [15:0] perf_cnt
`endif
);

  logic               fifo_full, fifo_empty, fifo_pop;
  logic [INSTR_W-1:0] fifo_rdata;
  seq_state_e         state_q, state_d;
  logic [RPT_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] act_q, act_d;
  uop_t               uop_q, uop_d;
  logic               issue;

  bslu_seq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INSTR_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .wdata_i (in_instr),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // cnt_q holds the micro-ops still owed by the active instruction
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    uop_d    = '0;
    fifo_pop = 1'b0;
    issue    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !stall) begin
          fifo_pop = 1'b1;
          act_d    = fifo_rdata;
          cnt_d    = fifo_rdata[F_RPT_LO +: RPT_W];
          uop_d    = decode_uop(fifo_rdata);
          issue    = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cnt_q != '0) begin
          if (!stall) begin
            cnt_d = RPT_W'(cnt_q - 1'b1);
            uop_d = decode_uop(act_q);
            issue = 1'b1;
          end
        end else if (!fifo_empty) begin
          // back-to-back: the next instruction's first micro-op follows directly
          if (!stall) begin
            fifo_pop = 1'b1;
            act_d    = fifo_rdata;
            cnt_d    = fifo_rdata[F_RPT_LO +: RPT_W];
            uop_d    = decode_uop(fifo_rdata);
            issue    = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      act_q   <= '0;
      uop_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      uop_q   <= uop_d;
    end
  end

  assign in_ready = !fifo_full;
  assign busy     = (state_q == ST_ISSUE) || !fifo_empty;
  assign op       = uop_q.op;
  assign rs1      = uop_q.rs1;
  assign rs2      = uop_q.rs2;
  assign rd       = uop_q.rd;

`ifdef BSLU_SEQ_PERF_CNT_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        perf_q <= '0;
    else if (issue) perf_q <= perf_q + 16'd1;
  end

  assign perf_cnt = perf_q;
`else
  logic unused_issue;
  assign unused_issue = issue;
`endif

endmodule

// File: tb/tb_bslu_bs3r_seq.sv
// Scoreboard bench for bslu_bs3r_seq: expected micro-ops are queued on push
// and compared whenever the DUT shows a non-zero op.
module tb_bslu_bs3r_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, stall, stall_man, stall_rnd, rnd_en;
  logic [15:0] in_instr;
  logic [3:0]  rs1, rs2, rd;
  logic [7:0]  op;
  logic        busy;
`ifdef BSLU_SEQ_PERF_CNT_EN
  logic [15:0] perf_cnt;
`endif

  assign stall = stall_man | stall_rnd;

  bslu_bs3r_seq #(.FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .stall    (stall),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .op       (op),
    .busy     (busy)
`ifdef BSLU_SEQ_PERF_CNT_EN
    ,
    .perf_cnt (perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int issues = 0, segs = 0;
  logic prev_nz = 1'b0;
  logic [19:0] sbq[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int opc, input int imm, input int rdi,
                                     input int r1, input int r2, input int rpt);
    logic [15:0] w;
    w = {3'(opc), 1'(imm), 2'(rdi), 2'(r1), 2'(r2), 6'(rpt)};
    return w;
  endfunction

  // reference expansion of one instruction into its visible micro-ops
  function automatic void expect_instr(input logic [15:0] ins);
    logic [7:0] eop;
    logic [3:0] ers1, ers2, erd;
    erd  = 4'b0001 << ins[11:10];
    ers1 = 4'b0001 << ins[9:8];
    ers2 = 4'b0001 << ins[7:6];
    case (ins[15:13])
      3'd1: begin eop = 8'h01; ers2 = 4'h0; end
      3'd2: begin eop = ins[12] ? 8'h06 : 8'h02; ers1 = 4'h0; ers2 = 4'h0; end
      3'd3: begin eop = 8'h08; ers2 = 4'h0; end
      3'd4: eop = 8'h10;
      3'd5: eop = 8'h20;
      3'd6: eop = 8'h40;
      3'd7: eop = 8'h80;
      default: eop = 8'h00;
    endcase
    if (eop != 8'h00)
      for (int i = 0; i <= int'(ins[5:0]); i++) sbq.push_back({eop, ers1, ers2, erd});
  endfunction

  always @(negedge clk) begin
    if (op != 8'h00) begin
      issues++;
      if (!prev_nz) segs++;
      if (sbq.size() == 0) chk("unexpected_uop", 32'({op, rs1, rs2, rd}), 32'h0);
      else                 chk("uop", 32'({op, rs1, rs2, rd}), 32'(sbq.pop_front()));
    end else if ({rs1, rs2, rd} != 12'h0) begin
      chk("idle_selects", 32'({rs1, rs2, rd}), 32'h0);
    end
    prev_nz = (op != 8'h00);
  end

  always @(negedge clk) stall_rnd = rnd_en ? ($urandom_range(0, 2) == 0) : 1'b0;

  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  // returns at negedge+1 just after the accepting clock edge
  task automatic push_instr(input logic [15:0] ins);
    bit ok = 0;
    in_valid = 1'b1;
    in_instr = ins;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      nedge();
    end
    if (ok) expect_instr(ins);
    else    chk("push_timeout", 32'd0, 32'd1);
    nedge();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy && op == 8'h00) begin
        ok = 1;
        break;
      end
      nedge();
    end
    if (!ok) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, s0;
    logic [15:0] p0;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; stall_man = 1'b0; rnd_en = 1'b0;
    p0 = '0;
    repeat (3) nedge();
    chk("rst_op", 32'(op), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
`ifdef BSLU_SEQ_PERF_CNT_EN
    chk("rst_perf", 32'(perf_cnt), 32'h0);
`endif
    rst = 1'b0;
    nedge();
    chk("post_rst_sel", 32'({rs1, rs2, rd}), 32'h0);

    // set imm=1 rd=pr rpt=0: one-cycle latency, single micro-op
    push_instr(mk(2, 1, 2, 0, 0, 0));
    chk("lat_before", 32'(op), 32'h0);
    nedge();
    chk("set_op", 32'(op), 32'h06);
    chk("set_rd", 32'(rd), 32'h4);
    chk("set_rs", 32'({rs1, rs2}), 32'h0);
    nedge();
    chk("set_after", 32'(op), 32'h0);
    wait_idle("idle_timeout_set");

    // xor rd=sa rs1=cr rs2=t1 rpt=3: four contiguous identical micro-ops
    i0 = issues; s0 = segs;
    push_instr(mk(6, 0, 0, 1, 3, 3));
    wait_idle("idle_timeout_xor");
    chk("xor_issues", 32'(issues - i0), 32'd4);
    chk("xor_segments", 32'(segs - s0), 32'd1);

    // and rpt=2 with a one-cycle stall after the first micro-op
    i0 = issues; s0 = segs;
    push_instr(mk(4, 0, 3, 2, 1, 2));
    nedge();
    chk("and_first", 32'(op), 32'h10);
    stall_man = 1'b1;
    nedge();
    stall_man = 1'b0;
    chk("stall_gap", 32'(op), 32'h0);
    wait_idle("idle_timeout_and");
    chk("and_issues", 32'(issues - i0), 32'd3);
    chk("and_segments", 32'(segs - s0), 32'd2);

    // fill under stall, overflow push waits, then five issues with no bubble
    i0 = issues; s0 = segs;
    stall_man = 1'b1;
    push_instr(mk(1, 0, 0, 1, 0, 0));
    push_instr(mk(3, 0, 1, 2, 0, 0));
    push_instr(mk(7, 0, 2, 3, 0, 0));
    push_instr(mk(5, 0, 3, 0, 2, 0));
    chk("full_ready", 32'(in_ready), 32'h0);
    chk("full_no_issue", 32'(issues - i0), 32'd0);
    stall_man = 1'b0;
    push_instr(mk(2, 0, 1, 0, 0, 0));
    wait_idle("idle_timeout_fill");
    chk("fill_issues", 32'(issues - i0), 32'd5);
    chk("fill_segments", 32'(segs - s0), 32'd1);

    // nop rpt=5 followed by mov
`ifdef BSLU_SEQ_PERF_CNT_EN
    p0 = perf_cnt;
`endif
    push_instr(mk(0, 0, 0, 0, 0, 5));
    in_valid = 1'b1;
    push_instr(mk(1, 0, 0, 2, 0, 0));
    for (int i = 0; i < 6; i++) begin
      chk("nop_op", 32'(op), 32'h0);
      chk("nop_busy", 32'(busy), 32'h1);
      nedge();
    end
    chk("mov_op", 32'(op), 32'h01);
    chk("mov_sel", 32'({rs1, rs2, rd}), 32'h401);
`ifdef BSLU_SEQ_PERF_CNT_EN
    chk("perf_delta", 32'(16'(perf_cnt - p0)), 32'd7);
`else
    chk("perf_none", 32'(p0), 32'h0);
`endif
    wait_idle("idle_timeout_nop");

    // random instructions under random stall
    rnd_en = 1'b1;
    for (int n = 0; n < 10; n++)
      push_instr(mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
    wait_idle("idle_timeout_rand");
    rnd_en = 1'b0;
    nedge();
    chk("rand_drained", 32'(sbq.size()), 32'd0);

    // reset mid-repeat discards active and queued work
    push_instr(mk(6, 0, 1, 2, 3, 20));
    push_instr(mk(1, 0, 3, 0, 0, 0));
    nedge();
    rst = 1'b1;
    #1;
    chk("midrst_op", 32'(op), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_ready", 32'(in_ready), 32'h1);
`ifdef BSLU_SEQ_PERF_CNT_EN
    chk("midrst_perf", 32'(perf_cnt), 32'h0);
`endif
    sbq.delete();
    i0 = issues;
    in_valid = 1'b1;
    in_instr = mk(1, 0, 0, 0, 0, 0);
    nedge();
    nedge();
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (10) nedge();
    chk("postrst_issues", 32'(issues - i0), 32'd0);
    chk("postrst_busy", 32'(busy), 32'h0);
    chk("sb_left", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
